// File: rtl/burst_addr_aligner_if.sv
// Request / beat / response bundle for burst_addr_aligner.
// master = requester side, slave = the aligner itself.
interface burst_addr_aligner_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic [2:0]            req_size;
  logic [LEN_W-1:0]      req_len;
  logic                  req_inc;

  logic                  beat_valid;
  logic                  beat_ready;
  logic [ADDR_W-1:0]     beat_addr;
  logic [DATA_W/8-1:0]   beat_wstrb;
  logic                  beat_last;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [7:0]            rsp_status;

  modport master (
    output req_valid, req_addr, req_size, req_len, req_inc, beat_ready, rsp_ready,
    input  req_ready, beat_valid, beat_addr, beat_wstrb, beat_last, rsp_valid, rsp_status
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_len, req_inc, beat_ready, rsp_ready,
    output req_ready, beat_valid, beat_addr, beat_wstrb, beat_last, rsp_valid, rsp_status
  );
endinterface

// File: rtl/burst_addr_aligner.sv
// Splits a burst request into per-beat addresses and byte strobes, then reports a status.
// Optional 4 KiB page-crossing rejection: define BURST_ADDR_ALIGNER_4K_CHECK_EN.
module burst_addr_aligner #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  burst_addr_aligner_if.slave   bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_CMD_INV  = 8'h02;
  localparam logic [7:0] ST_ALIGN    = 8'h03;
`ifdef BURST_ADDR_ALIGNER_4K_CHECK_EN
  localparam logic [7:0] ST_BOUNDARY = 8'h04;
`endif

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                inc_q, inc_d;
  logic [7:0]          status_q, status_d;

  logic                size_err;
  logic                align_err;
  logic                page_err;
  logic [7:0]          chk_status;
`ifdef BURST_ADDR_ALIGNER_4K_CHECK_EN
  logic [LEN_W:0]      req_beats;
  logic [ADDR_W-1:0]   req_end;
`endif

  // Request validation, evaluated combinationally on the request fields in IDLE.
  always_comb begin
    size_err  = bus.req_size > 3'(OFF_W);
    align_err = (bus.req_addr & ((ADDR_W'(1) << bus.req_size) - ADDR_W'(1))) != '0;
`ifdef BURST_ADDR_ALIGNER_4K_CHECK_EN
    req_beats = {1'b0, bus.req_len} + {{LEN_W{1'b0}}, 1'b1};
    req_end   = bus.req_addr + (ADDR_W'(req_beats) << bus.req_size) - ADDR_W'(1);
    page_err  = bus.req_inc && (bus.req_addr[ADDR_W-1:12] != req_end[ADDR_W-1:12]);
`else
    page_err  = 1'b0;
`endif
    if (size_err)
      chk_status = ST_CMD_INV;
    else if (align_err)
      chk_status = ST_ALIGN;
`ifdef BURST_ADDR_ALIGNER_4K_CHECK_EN
    else if (page_err)
      chk_status = ST_BOUNDARY;
`endif
    else
      chk_status = ST_OK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      inc_q    <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      inc_q    <= inc_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    inc_d    = inc_q;
    status_d = status_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          size_d   = bus.req_size;
          len_d    = bus.req_len;
          inc_d    = bus.req_inc;
          cnt_d    = '0;
          status_d = chk_status;
          state_d  = (chk_status == ST_OK) ? BEAT : RESP;
        end
      end
      BEAT: begin
        if (bus.beat_ready) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (inc_q)
            addr_d = addr_q + (ADDR_W'(1) << size_q);
          if (cnt_q == len_q)
            state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.beat_valid = (state_q == BEAT);
    bus.beat_last  = (state_q == BEAT) && (cnt_q == len_q);
    bus.beat_addr  = addr_q;
    bus.rsp_valid  = (state_q == RESP);
    bus.rsp_status = status_q;
  end

  // Each lane is enabled when it falls in [offset, offset + bytes_per_beat).
  logic [7:0]        off_ext;
  logic [7:0]        end_ext;
  logic [STRB_W-1:0] strb;

  assign off_ext = 8'(addr_q[OFF_W-1:0]);
  assign end_ext = off_ext + (8'd1 << size_q);

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_strb
      assign strb[gi] = (state_q == BEAT) && (8'(gi) >= off_ext) && (8'(gi) < end_ext);
    end
  endgenerate

  assign bus.beat_wstrb = strb;
endmodule

// File: tb/tb_burst_addr_aligner.sv
// Table-driven directed vectors plus randomized bursts for burst_addr_aligner,
// checked against a byte-arithmetic reference model.
module tb_burst_addr_aligner;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  burst_addr_aligner_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  burst_addr_aligner #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_txn = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Beats and responses must never overlap.
  always @(negedge clk) begin
    if (!rst)
      chk("beat_rsp_exclusive", 64'(bus.beat_valid & bus.rsp_valid), 64'd0);
  end

  // Reference model: expected status and beat list from byte arithmetic.
  logic [31:0] m_addr[$];
  logic [3:0]  m_strb[$];
  bit          m_last[$];
  logic [7:0]  m_status;

  function automatic void model(input logic [31:0] addr, input int size, input int len, input bit inc);
    longint unsigned a64, bytes, last_byte, cur;
    int s;
    m_addr.delete();
    m_strb.delete();
    m_last.delete();
    a64   = 64'(addr);
    bytes = 64'(1) << size;
    last_byte = (a64 + 64'(len + 1) * bytes - 64'd1) & 64'hFFFF_FFFF;
    if (size > 2)
      m_status = 8'h02;
    else if ((a64 % bytes) != 0)
      m_status = 8'h03;
`ifdef BURST_ADDR_ALIGNER_4K_CHECK_EN
    else if (inc && ((a64 >> 12) != (last_byte >> 12)))
      m_status = 8'h04;
`endif
    else begin
      m_status = 8'h00;
      for (int k = 0; k <= len; k++) begin
        cur = inc ? ((a64 + 64'(k) * bytes) & 64'hFFFF_FFFF) : a64;
        s   = ((1 << int'(bytes)) - 1) << int'(cur % 4);
        m_addr.push_back(32'(cur));
        m_strb.push_back(4'(s));
        m_last.push_back(k == len);
      end
    end
    if (last_byte == 64'hFFFF_FFFF_FFFF) m_status = 8'hFF;
  endfunction

  task automatic run_txn(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                         input bit inc, input int stall, input bit rnd,
                         output logic [7:0] st, output int nb, output logic [31:0] fa, output logic [3:0] fs);
    int cyc;
    int nb_exp;
    int hold;
    bit held;
    bit rdy;
    logic [31:0] h_addr;
    logic [3:0]  h_strb;
    logic        h_last;
    model(addr, int'(size), int'(len), inc);
    nb_exp = m_addr.size();
    nb = 0; fa = '0; fs = '0;
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_len   = len;
    bus.req_inc   = inc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (m_status != 8'h00) begin
      chk("err_rsp_latency", 64'(bus.rsp_valid), 64'd1);
      chk("err_no_beat", 64'(bus.beat_valid), 64'd0);
    end else begin
      chk("beat_latency", 64'(bus.beat_valid), 64'd1);
    end
    cyc = 0; held = 0;
    while (!bus.rsp_valid && cyc < 2000) begin
      if (bus.beat_valid) begin
        if (held) begin
          chk("stall_addr", 64'(bus.beat_addr), 64'(h_addr));
          chk("stall_wstrb", 64'(bus.beat_wstrb), 64'(h_strb));
          chk("stall_last", 64'(bus.beat_last), 64'(h_last));
        end
        if (nb == 0) begin
          fa = bus.beat_addr;
          fs = bus.beat_wstrb;
        end
        if (stall > 0) begin
          rdy = 1'b0; stall--;
        end else begin
          rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        bus.beat_ready = rdy;
        if (rdy) begin
          held = 0;
          if (m_addr.size() == 0) begin
            chk("extra_beat", 64'd1, 64'd0);
          end else begin
            chk("beat_addr", 64'(bus.beat_addr), 64'(m_addr.pop_front()));
            chk("beat_wstrb", 64'(bus.beat_wstrb), 64'(m_strb.pop_front()));
            chk("beat_last", 64'(bus.beat_last), 64'(m_last.pop_front()));
          end
          nb++;
        end else begin
          held = 1;
          h_addr = bus.beat_addr;
          h_strb = bus.beat_wstrb;
          h_last = bus.beat_last;
        end
      end
      @(posedge clk); #1; cyc++;
    end
    bus.beat_ready = 1'b0;
    chk("rsp_timeout", 64'(bus.rsp_valid), 64'd1);
    chk("beat_count", 64'(nb), 64'(nb_exp));
    st = bus.rsp_status;
    chk("rsp_status", 64'(st), 64'(m_status));
    hold = rnd ? int'($urandom_range(0, 2)) : 1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("rsp_hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("rsp_hold_status", 64'(bus.rsp_status), 64'(m_status));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 64'(bus.rsp_valid), 64'd0);
    chk("req_ready_after_rsp", 64'(bus.req_ready), 64'd1);
    n_txn++;
    $display("txn %0d addr=0x%08h size=%0d len=%0d inc=%0d beats=%0d status=0x%02h",
             n_txn, addr, size, len, inc, nb, st);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  64'(bus.req_ready),  64'd1);
    chk({tag, "_beat_valid"}, 64'(bus.beat_valid), 64'd0);
    chk({tag, "_rsp_valid"},  64'(bus.rsp_valid),  64'd0);
    chk({tag, "_beat_addr"},  64'(bus.beat_addr),  64'd0);
    chk({tag, "_beat_wstrb"}, 64'(bus.beat_wstrb), 64'd0);
    chk({tag, "_beat_last"},  64'(bus.beat_last),  64'd0);
    chk({tag, "_rsp_status"}, 64'(bus.rsp_status), 64'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
    bit          inc;
    int          stall;
    logic [7:0]  exp_st;
    int          exp_nb;
    logic [31:0] exp_fa;
    logic [3:0]  exp_fs;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0]  st;
    int          nb;
    logic [31:0] fa;
    logic [3:0]  fs;
    logic [31:0] r_addr;
    logic [2:0]  r_size;

    tbl[0] = '{32'h0000_1000, 3'd2, 8'd3,   1'b1, 0, 8'h00, 4,   32'h0000_1000, 4'hF};
    tbl[1] = '{32'h0000_2003, 3'd0, 8'd1,   1'b1, 0, 8'h00, 2,   32'h0000_2003, 4'h8};
    tbl[2] = '{32'h0000_0011, 3'd1, 8'd0,   1'b1, 0, 8'h03, 0,   32'h0,         4'h0};
    tbl[3] = '{32'h0000_0100, 3'd3, 8'd0,   1'b1, 0, 8'h02, 0,   32'h0,         4'h0};
    tbl[4] = '{32'h0000_0040, 3'd2, 8'd2,   1'b0, 5, 8'h00, 3,   32'h0000_0040, 4'hF};
`ifdef BURST_ADDR_ALIGNER_4K_CHECK_EN
    tbl[5] = '{32'h0000_0FFC, 3'd2, 8'd1,   1'b1, 0, 8'h04, 0,   32'h0,         4'h0};
    tbl[7] = '{32'hFFFF_FFFC, 3'd2, 8'd1,   1'b1, 0, 8'h04, 0,   32'h0,         4'h0};
`else
    tbl[5] = '{32'h0000_0FFC, 3'd2, 8'd1,   1'b1, 0, 8'h00, 2,   32'h0000_0FFC, 4'hF};
    tbl[7] = '{32'hFFFF_FFFC, 3'd2, 8'd1,   1'b1, 0, 8'h00, 2,   32'hFFFF_FFFC, 4'hF};
`endif
    tbl[6] = '{32'h0000_3000, 3'd0, 8'd255, 1'b1, 0, 8'h00, 256, 32'h0000_3000, 4'h1};

    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_size   = '0;
    bus.req_len    = '0;
    bus.req_inc    = 1'b0;
    bus.beat_ready = 1'b0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].addr, tbl[i].size, tbl[i].len, tbl[i].inc, tbl[i].stall, 1'b0, st, nb, fa, fs);
      chk("tbl_status", 64'(st), 64'(tbl[i].exp_st));
      chk("tbl_beats", 64'(nb), 64'(tbl[i].exp_nb));
      if (tbl[i].exp_nb > 0) begin
        chk("tbl_first_addr", 64'(fa), 64'(tbl[i].exp_fa));
        chk("tbl_first_wstrb", 64'(fs), 64'(tbl[i].exp_fs));
      end
    end

    // Reset in the middle of a len=7 burst, during its second beat.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0100;
    bus.req_size  = 3'd2;
    bus.req_len   = 8'd7;
    bus.req_inc   = 1'b1;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.beat_ready = 1'b1;
    @(posedge clk); #1;
    chk("midburst_second_beat", 64'(bus.beat_addr), 64'h104);
    rst = 1'b1;
    bus.beat_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_outputs("midburst_rst");
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("midburst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end

    // Reset while a response is pending.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0011;
    bus.req_size  = 3'd1;
    bus.req_len   = 8'd0;
    bus.req_inc   = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("resp_rst_pending", 64'(bus.rsp_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_outputs("resp_rst");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("resp_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      r_size = 3'($urandom_range(0, 3));
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0)
        r_addr = (r_addr >> r_size) << r_size;
      run_txn(r_addr, r_size, 8'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), 1'b1, st, nb, fa, fs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/burst_addr_aligner.md
BURST_ADDR_ALIGNER -- requirements
Module: burst_addr_aligner

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the AXI data width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the address width in bits.
REQ-003 The block SHALL have parameter LEN_W, default 8, giving the width of the beat-count field, which encodes beats minus 1.
REQ-004 The block SHALL have ports clk (in, 1, the single clock) and rst (in, 1, synchronous active-high reset).
REQ-005 The request channel SHALL be: req_valid (in, 1); req_ready (out, 1); req_addr (in, ADDR_W); req_size (in, 3, log2 bytes per beat); req_len (in, LEN_W); req_inc (in, 1, 1 = incrementing, 0 = fixed address).
REQ-006 The beat channel SHALL be: beat_valid (out, 1); beat_ready (in, 1); beat_addr (out, ADDR_W); beat_wstrb (out, DATA_W/8); beat_last (out, 1).
REQ-007 The response channel SHALL be: rsp_valid (out, 1); rsp_ready (in, 1); rsp_status (out, 8).

Function
REQ-008 The FSM SHALL have states IDLE, BEAT and RESP, with req_ready = 1 only in IDLE.
REQ-009 A request SHALL be accepted on a cycle where req_valid & req_ready, and its fields SHALL be registered on that cycle.
REQ-010 Validation on acceptance:
- req_size > log2(DATA_W/8) SHALL give status 0x02 (CMD_INV).
- Otherwise, req_addr not a multiple of 2^req_size SHALL give status 0x03 (ADDR_ALIGN).
REQ-011 On a validation error the FSM SHALL go IDLE->RESP, emit no beats, and assert rsp_valid on the next cycle.
REQ-012 On a valid request the FSM SHALL go IDLE->BEAT, with beat_valid asserted on the cycle after acceptance (latency 1).
REQ-013 beat_wstrb SHALL equal (2^(2^size) - 1) shifted left by beat_addr[log2(DATA_W/8)-1:0].
REQ-014 The beat address SHALL be updated on each accepted beat (beat_valid & beat_ready):
- incrementing mode: beat_addr += 2^size, modulo 2^ADDR_W;
- fixed mode: beat_addr unchanged.
REQ-015 A beat counter SHALL run from 0 to req_len; beat_last SHALL be 1 only when the counter equals req_len, and req_len = 2^LEN_W - 1 SHALL yield 2^LEN_W beats.
REQ-016 While beat_valid = 1 and beat_ready = 0, beat_addr, beat_wstrb and beat_last SHALL hold stable.
REQ-017 Acceptance of the last beat SHALL move the FSM BEAT->RESP with rsp_status = 0x00 and rsp_valid on the next cycle.
REQ-018 rsp_valid and rsp_status SHALL hold until rsp_ready; the handshake SHALL return the FSM to IDLE, and req_ready SHALL rise the following cycle.
REQ-019 beat_valid and rsp_valid SHALL never be asserted simultaneously.

Reset
REQ-020 While rst = 1 at a clk edge, the FSM SHALL enter IDLE, and on the following cycle the outputs SHALL be: req_ready = 1, beat_valid = 0, rsp_valid = 0, beat_addr = 0, beat_wstrb = 0, beat_last = 0, rsp_status = 0.
REQ-021 Reset asserted mid-burst or in RESP SHALL abandon the transaction with no response generated.

Configuration
REQ-022 When macro BURST_ADDR_ALIGNER_4K_CHECK_EN is defined, an incrementing request whose last byte addr + (req_len+1)*2^size - 1 lies in a different 4 KiB page than addr SHALL be rejected with status 0x04 (ADDR_BOUNDARY) and no beats; this check SHALL be evaluated after the 0x02 and 0x03 checks.
REQ-023 When the macro is undefined, there SHALL be no boundary check, and addresses SHALL wrap modulo 2^ADDR_W.

Verification
REQ-024 size=2, addr=0x1000, len=3, inc=1 -> beats at 0x1000/0x1004/0x1008/0x100C, wstrb 0xF, last on the 4th beat, then rsp 0x00.
REQ-025 size=0, addr=0x2003, len=1, inc=1 -> beat 0x2003 with wstrb 0x8, then beat 0x2004 with wstrb 0x1 and last=1.
REQ-026 Error requests:
- size=1, addr=0x11 -> no beats, rsp_valid the cycle after acceptance with status 0x03.
- size=3 with DATA_W=32 -> status 0x02.
REQ-027 size=2, addr=0x40, len=2, inc=0, beat_ready held low 5 cycles -> outputs stable during stall, 3 beats all at 0x40, rsp 0x00.
REQ-028 addr=0x0FFC, size=2, len=1:
- macro defined -> status 0x04, no beats;
- macro undefined -> beats 0x0FFC and 0x1000, then rsp 0x00.
REQ-029 rst pulsed during the 2nd beat of a len=7 burst -> beat_valid=0 and req_ready=1 the next cycle, with no rsp_valid.
